// File: rtl/issue_arbiter_if.sv
// rtl/issue_arbiter_if.sv - reservation-station / issue-arbiter handshake bundle
interface issue_arbiter_if #(
    parameter int RS_ROW_COUNT = 64,
    parameter int IDX_W        = 6
);
    logic [RS_ROW_COUNT-1:0] rs_valid;
    logic [RS_ROW_COUNT-1:0] rs_ready;
    logic [RS_ROW_COUNT-1:0] rs_is_mem;
    logic                    mem_stall;
    logic [2:0]              issue_valid;
    logic [IDX_W-1:0]        issue_idx0;
    logic [IDX_W-1:0]        issue_idx1;
    logic [IDX_W-1:0]        issue_idx2;
    logic [RS_ROW_COUNT-1:0] rs_clear;
    logic [2:0]              fu_avail;

    modport master (
        output rs_valid, rs_ready, rs_is_mem, mem_stall,
        input  issue_valid, issue_idx0, issue_idx1, issue_idx2, rs_clear, fu_avail
    );

    modport slave (
        input  rs_valid, rs_ready, rs_is_mem, mem_stall,
        output issue_valid, issue_idx0, issue_idx1, issue_idx2, rs_clear, fu_avail
    );
endinterface

// File: rtl/issue_arbiter.sv
// rtl/issue_arbiter.sv - round-robin issue scheduler for two ALUs and one MEM unit
module issue_arbiter #(
    parameter int RS_ROW_COUNT = 64,
    parameter int IDX_W        = 6,
    parameter int ALU_LATENCY  = 1,
    parameter int MEM_LATENCY  = 3
) (
    input  logic           clk,
    input  logic           reset,
    issue_arbiter_if.slave bus
);
    localparam int ACW = $clog2(ALU_LATENCY) + 1;
    localparam int MCW = $clog2(MEM_LATENCY) + 1;

    logic [2:0]              issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]        issue_idx0_q, issue_idx0_d;
    logic [IDX_W-1:0]        issue_idx1_q, issue_idx1_d;
    logic [IDX_W-1:0]        issue_idx2_q, issue_idx2_d;
    logic [RS_ROW_COUNT-1:0] rs_clear_q, rs_clear_d;
    logic [2:0]              fu_avail_q, fu_avail_d;
    logic [IDX_W-1:0]        alu_ptr_q, alu_ptr_d;
    logic [IDX_W-1:0]        mem_ptr_q, mem_ptr_d;
    logic [1:0][ACW-1:0]     alu_cnt_q, alu_cnt_d;
    logic [MCW-1:0]          mem_cnt_q, mem_cnt_d;

    logic [RS_ROW_COUNT-1:0] cand, alu_cand, mem_cand;
    logic                    alu_hit_a, alu_hit_b, mem_hit;
    logic [IDX_W-1:0]        alu_idx_a, alu_idx_b, mem_idx;
    logic [IDX_W-1:0]        scan_a, scan_m;
    logic                    alu0_free, alu1_free, mem_free;
    logic                    gnt0, gnt1, gntm;
    logic [IDX_W-1:0]        last_alu;

    always_comb begin
        // Entries shown on rs_clear this cycle are still valid at the parent; mask them.
        cand     = bus.rs_valid & bus.rs_ready & ~rs_clear_q;
        alu_cand = cand & ~bus.rs_is_mem;
        mem_cand = cand & bus.rs_is_mem;

        alu_hit_a = 1'b0;
        alu_hit_b = 1'b0;
        alu_idx_a = '0;
        alu_idx_b = '0;
        mem_hit   = 1'b0;
        mem_idx   = '0;
        scan_a    = '0;
        scan_m    = '0;
        for (int j = 0; j < RS_ROW_COUNT; j++) begin
            scan_a = alu_ptr_q + IDX_W'(j);
            scan_m = mem_ptr_q + IDX_W'(j);
            if (alu_cand[scan_a]) begin
                if (!alu_hit_a) begin
                    alu_hit_a = 1'b1;
                    alu_idx_a = scan_a;
                end else if (!alu_hit_b) begin
                    alu_hit_b = 1'b1;
                    alu_idx_b = scan_a;
                end
            end
            if (mem_cand[scan_m] && !mem_hit) begin
                mem_hit = 1'b1;
                mem_idx = scan_m;
            end
        end

        alu0_free = (alu_cnt_q[0] == '0);
        alu1_free = (alu_cnt_q[1] == '0);
        mem_free  = (mem_cnt_q == '0) && !bus.mem_stall;

        // First hit goes to the lowest free ALU; ALU1 takes the second only when ALU0 took the first.
        gnt0         = alu_hit_a && alu0_free;
        gnt1         = alu0_free ? (alu_hit_b && alu1_free) : (alu_hit_a && alu1_free);
        gntm         = mem_hit && mem_free;
        issue_idx0_d = gnt0 ? alu_idx_a : '0;
        issue_idx1_d = gnt1 ? (alu0_free ? alu_idx_b : alu_idx_a) : '0;
        issue_idx2_d = gntm ? mem_idx : '0;
        issue_valid_d = {gntm, gnt1, gnt0};

        rs_clear_d = '0;
        if (gnt0) rs_clear_d[issue_idx0_d] = 1'b1;
        if (gnt1) rs_clear_d[issue_idx1_d] = 1'b1;
        if (gntm) rs_clear_d[issue_idx2_d] = 1'b1;

        last_alu  = gnt1 ? issue_idx1_d : issue_idx0_d;
        alu_ptr_d = (gnt0 || gnt1) ? last_alu + IDX_W'(1) : alu_ptr_q;
        mem_ptr_d = gntm ? mem_idx + IDX_W'(1) : mem_ptr_q;

        for (int k = 0; k < 2; k++) begin
            alu_cnt_d[k] = (alu_cnt_q[k] != '0) ? alu_cnt_q[k] - ACW'(1) : '0;
        end
        if (gnt0) alu_cnt_d[0] = ACW'(ALU_LATENCY - 1);
        if (gnt1) alu_cnt_d[1] = ACW'(ALU_LATENCY - 1);

        if (gntm)                    mem_cnt_d = MCW'(MEM_LATENCY - 1);
        else if (bus.mem_stall)      mem_cnt_d = mem_cnt_q;
        else if (mem_cnt_q != '0)    mem_cnt_d = mem_cnt_q - MCW'(1);
        else                         mem_cnt_d = '0;

        fu_avail_d = {(mem_cnt_d == '0) && !bus.mem_stall,
                      alu_cnt_d[1] == '0,
                      alu_cnt_d[0] == '0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q <= '0;
            issue_idx0_q  <= '0;
            issue_idx1_q  <= '0;
            issue_idx2_q  <= '0;
            rs_clear_q    <= '0;
            fu_avail_q    <= 3'b111;
            alu_ptr_q     <= '0;
            mem_ptr_q     <= '0;
            alu_cnt_q     <= '0;
            mem_cnt_q     <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_idx0_q  <= issue_idx0_d;
            issue_idx1_q  <= issue_idx1_d;
            issue_idx2_q  <= issue_idx2_d;
            rs_clear_q    <= rs_clear_d;
            fu_avail_q    <= fu_avail_d;
            alu_ptr_q     <= alu_ptr_d;
            mem_ptr_q     <= mem_ptr_d;
            alu_cnt_q     <= alu_cnt_d;
            mem_cnt_q     <= mem_cnt_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_idx0  = issue_idx0_q;
    assign bus.issue_idx1  = issue_idx1_q;
    assign bus.issue_idx2  = issue_idx2_q;
    assign bus.rs_clear    = rs_clear_q;
    assign bus.fu_avail    = fu_avail_q;
endmodule

// File: tb/tb_issue_arbiter.sv
// tb/tb_issue_arbiter.sv - scoreboard bench for issue_arbiter
module tb_issue_arbiter;
    localparam int N    = 64;
    localparam int W    = 6;
    localparam int ALAT = 1;
    localparam int MLAT = 3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    issue_arbiter_if #(.RS_ROW_COUNT(N), .IDX_W(W)) bus ();

    issue_arbiter #(.RS_ROW_COUNT(N), .IDX_W(W), .ALU_LATENCY(ALAT), .MEM_LATENCY(MLAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [2:0]   iv;
        int           i0, i1, i2;
        logic [N-1:0] clr;
        logic [2:0]   fa;
    } exp_t;

    exp_t         sb[$];
    int           m_aptr, m_mptr, m_mrem;
    int           m_arem[2];
    logic [N-1:0] m_clear;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: ordered candidate lists, free units take them in scan order.
    task automatic model_eval();
        exp_t e;
        int   alu_hits[$];
        int   mem_hits[$];
        int   slots[$];
        bit   fm;
        e.due = cyc + 1; e.iv = '0; e.i0 = 0; e.i1 = 0; e.i2 = 0; e.clr = '0;
        if (reset) begin
            m_aptr = 0; m_mptr = 0; m_mrem = 0; m_arem[0] = 0; m_arem[1] = 0;
            m_clear = '0;
            e.fa = 3'b111;
            sb.push_back(e);
            return;
        end
        for (int j = 0; j < N; j++) begin
            int ia = (m_aptr + j) % N;
            int im = (m_mptr + j) % N;
            if (bus.rs_valid[ia] && bus.rs_ready[ia] && !m_clear[ia] && !bus.rs_is_mem[ia]) alu_hits.push_back(ia);
            if (bus.rs_valid[im] && bus.rs_ready[im] && !m_clear[im] && bus.rs_is_mem[im]) mem_hits.push_back(im);
        end
        if (m_arem[0] == 0) slots.push_back(0);
        if (m_arem[1] == 0) slots.push_back(1);
        fm = (m_mrem == 0) && !bus.mem_stall;
        for (int k = 0; k < 2; k++) if (m_arem[k] > 0) m_arem[k]--;
        if (!bus.mem_stall && m_mrem > 0) m_mrem--;
        for (int k = 0; k < slots.size() && k < alu_hits.size(); k++) begin
            e.iv[slots[k]] = 1'b1;
            if (slots[k] == 0) e.i0 = alu_hits[k]; else e.i1 = alu_hits[k];
            e.clr[alu_hits[k]] = 1'b1;
            m_arem[slots[k]] = ALAT - 1;
            m_aptr = (alu_hits[k] + 1) % N;
        end
        if (fm && mem_hits.size() > 0) begin
            e.iv[2] = 1'b1;
            e.i2 = mem_hits[0];
            e.clr[mem_hits[0]] = 1'b1;
            m_mrem = MLAT - 1;
            m_mptr = (mem_hits[0] + 1) % N;
        end
        e.fa = {(m_mrem == 0) && !bus.mem_stall, m_arem[1] == 0, m_arem[0] == 0};
        m_clear = e.clr;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("due_cycle", 64'(e.due), 64'(cyc));
            chk("issue_valid", 64'(bus.issue_valid), 64'(e.iv));
            if (e.iv[0]) chk("issue_idx0", 64'(bus.issue_idx0), 64'(e.i0));
            if (e.iv[1]) chk("issue_idx1", 64'(bus.issue_idx1), 64'(e.i1));
            if (e.iv[2]) chk("issue_idx2", 64'(bus.issue_idx2), 64'(e.i2));
            chk("rs_clear", bus.rs_clear, e.clr);
            chk("fu_avail", 64'(bus.fu_avail), 64'(e.fa));
        end
    end

    // Parent contract: entries shown on rs_clear drop out of rs_valid at the next edge.
    task automatic step();
        logic [N-1:0] shown;
        shown = m_clear;
        model_eval();
        @(posedge clk);
        #1;
        bus.rs_valid = bus.rs_valid & ~shown;
    endtask

    task automatic do_reset();
        bus.rs_valid = '0; bus.rs_ready = '0; bus.rs_is_mem = '0; bus.mem_stall = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.rs_valid = '0; bus.rs_ready = '0; bus.rs_is_mem = '0; bus.mem_stall = 1'b0;
        m_clear = '0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_valid", 64'(bus.issue_valid), 64'd0);
        chk("reset_avail", 64'(bus.fu_avail), 64'h7);

        // All ready, arithmetic only
        bus.rs_valid = '1; bus.rs_ready = '1;
        step();
        chk("all_iv", 64'(bus.issue_valid), 64'h3);
        chk("all_i0", 64'(bus.issue_idx0), 64'd0);
        chk("all_i1", 64'(bus.issue_idx1), 64'd1);
        chk("all_clr", bus.rs_clear, 64'h3);
        step();
        chk("all_i0b", 64'(bus.issue_idx0), 64'd2);
        chk("all_i1b", 64'(bus.issue_idx1), 64'd3);

        // MEM latency spacing
        do_reset();
        bus.rs_is_mem = 64'h60; bus.rs_valid = 64'h60; bus.rs_ready = 64'h60;
        step();
        chk("mem_first", 64'(bus.issue_valid), 64'h4);
        chk("mem_idx5", 64'(bus.issue_idx2), 64'd5);
        step();
        chk("mem_busy1", 64'(bus.issue_valid[2]), 64'd0);
        step();
        chk("mem_busy2", 64'(bus.issue_valid[2]), 64'd0);
        step();
        chk("mem_second", 64'(bus.issue_valid[2]), 64'd1);
        chk("mem_idx6", 64'(bus.issue_idx2), 64'd6);

        // Stall holds a waiting MEM op
        do_reset();
        bus.rs_is_mem = 64'h200; bus.rs_valid = 64'h200; bus.rs_ready = 64'h200;
        bus.mem_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_nogrant", 64'(bus.issue_valid[2]), 64'd0);
            chk("stall_avail", 64'(bus.fu_avail[2]), 64'd0);
        end
        bus.mem_stall = 1'b0;
        step();
        chk("stall_release", 64'(bus.issue_valid[2]), 64'd1);
        chk("stall_idx9", 64'(bus.issue_idx2), 64'd9);

        // Pointer wrap: drive alu_ptr to 62, then 63 and 0 compete
        do_reset();
        bus.rs_valid = {2'b00, {62{1'b1}}}; bus.rs_ready = '1;
        for (int k = 0; k < 31; k++) step();
        bus.rs_valid = bus.rs_valid | 64'h8000_0000_0000_0001;
        step();
        chk("wrap_iv", 64'(bus.issue_valid), 64'h3);
        chk("wrap_i0", 64'(bus.issue_idx0), 64'd63);
        chk("wrap_i1", 64'(bus.issue_idx1), 64'd0);
        step();
        bus.rs_valid = 64'h5;
        step();
        chk("ptr1_i0", 64'(bus.issue_idx0), 64'd2);
        chk("ptr1_i1", 64'(bus.issue_idx1), 64'd0);

        // Entry still valid during its rs_clear cycle is not re-granted
        do_reset();
        bus.rs_valid = 64'h10; bus.rs_ready = 64'h10;
        step();
        chk("once_iv", 64'(bus.issue_valid), 64'h1);
        chk("once_idx", 64'(bus.issue_idx0), 64'd4);
        step();
        chk("once_noregrant", 64'(bus.issue_valid), 64'h0);

        // Reset mid-occupancy
        do_reset();
        bus.rs_is_mem = 64'h1408; bus.rs_valid = 64'h1408; bus.rs_ready = 64'h1408;
        step();
        chk("rst_pre_idx", 64'(bus.issue_idx2), 64'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_iv", 64'(bus.issue_valid), 64'd0);
        chk("rst_clr", bus.rs_clear, 64'd0);
        chk("rst_avail", 64'(bus.fu_avail), 64'h7);
        step();
        chk("rst_post_idx", 64'(bus.issue_idx2), 64'd10);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.rs_valid[i] && ($urandom % 8 == 0)) begin
                    bus.rs_valid[i]  = 1'b1;
                    bus.rs_is_mem[i] = ($urandom % 3 == 0);
                    bus.rs_ready[i]  = $urandom % 2;
                end else if (bus.rs_valid[i] && !bus.rs_ready[i]) begin
                    bus.rs_ready[i] = $urandom % 2;
                end
            end
            bus.mem_stall = ($urandom % 5 == 0);
            reset = ($urandom % 300 == 0);
            step();
        end
        reset = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
